i2s_sample_feeder: RTL and testbench
====================================

# i2s_sample_feeder

Sample buffer sitting directly upstream of the I2S DAC transmitter. It accepts 32-bit audio words from the DSP datapath over a valid/ready push port and stores them in a DEPTH-entry FIFO. It serves one word per transmitter request. It outputs silence and reports underruns when starved, and re-primes before resuming real data, so the transmitter never stalls.

## Interface
- DATA_W, 32, audio word width (one I2S frame word)
- DEPTH, 256, FIFO entries; power of two
- PRIME_LVL, 128, fill level required before real data is served; LOW_WM < PRIME_LVL <= DEPTH
- LOW_WM, 16, low-water threshold
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  DATA_W  sample from DSP
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; push = in_valid & in_ready
- flush  in  1  synchronous clear of buffer and state
- tx_req  in  1  single-cycle request from transmitter for next word
- tx_data  out  DATA_W  word for transmitter; held between requests
- tx_valid  out  1  one-cycle strobe: tx_data updated
- underrun  out  1  one-cycle strobe on entry to UNDERRUN
- underrun_cnt  out  16  saturating count of underrun entries
- level  out  log2(DEPTH)+1  current fill count
- low_water  out  1  level < LOW_WM

## Operation
- States: IDLE (not primed), RUN, UNDERRUN.
- Reset: state IDLE; pointers 0; level 0; in_ready 1; tx_data 0; tx_valid 0; underrun 0; underrun_cnt 0; low_water 1.
- IDLE → RUN when level >= PRIME_LVL. In IDLE, tx_req is answered with tx_data = 0, and the FIFO is not popped.
- RUN, tx_req with level > 0: pop the head word; it appears on tx_data.
- RUN, tx_req with level == 0: answer 0; go to UNDERRUN; pulse underrun; underrun_cnt += 1, saturating at 0xFFFF.
- UNDERRUN: tx_req is answered with 0, with no further counting. UNDERRUN → RUN when level >= PRIME_LVL.
- Push accepted only when level < DEPTH; in_ready = (level < DEPTH). A pop in the same cycle does not make a full FIFO accept a push.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level is a separate counter, so full (DEPTH) and empty (0) are distinct.
- flush has priority over push, pop and tx_req in the same cycle. It clears pointers and level, sets state to IDLE and tx_data to 0, and drops any request in that cycle (no tx_valid). underrun_cnt is preserved.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any word in flight is lost.

## Timing
- tx_req sampled at edge N → tx_data and tx_valid valid after edge N+1 (latency 1). tx_valid is high for exactly one cycle.
- Consecutive tx_req on back-to-back cycles are supported, one word per cycle.
- Push at edge N → level increments after edge N; in_ready reflects the new level at N+1.
- A word pushed at edge N is poppable by a tx_req sampled at edge N+1 or later.
- State transitions take effect at the edge following the triggering condition. The priming check uses the registered level.
- underrun pulses in the same cycle as the tx_valid carrying the first silence word.
- low_water is registered from level with no additional latency beyond level.

## Structure
- Shared package audio_pkg: AUDIO_W = 32, feeder state enum (IDLE/RUN/UNDERRUN), UNDERRUN_CNT_W = 16. These are shared with the I2S transmitter and the DSP stage.
- Sub-module sample_ram: DEPTH × DATA_W simple dual-port memory with a registered read port, so it maps to block RAM. Pointer, level, FSM and counter logic stay in i2s_sample_feeder.

## Test plan
- Priming: reset, push 127 words 0x1..0x7F, tx_req → tx_data 0, no pop, level 127. Push a 128th word, wait one cycle, tx_req → tx_data 0x1, level 127.
- Streaming order: prime with 0x100..0x17F, then issue 128 tx_req on back-to-back cycles. Required: tx_data sequence 0x100..0x17F, each with tx_valid one cycle after its request, no underrun.
- Underrun/recovery: after draining, tx_req → tx_data 0, underrun pulse, underrun_cnt 1. Further tx_req → 0 with count still 1. Push 128 words → RUN resumes with the first new word.
- Full: push 256 words with no requests → in_ready 0, level 256. The 257th push with a simultaneous tx_req is not accepted; level becomes 255 and in_ready returns to 1.
- Flush vs. traffic: flush asserted together with push and tx_req at level 200. Required: level 0, state IDLE, no tx_valid, tx_data 0, underrun_cnt unchanged.
- Saturation/reset: force 65536 underrun entries → underrun_cnt stays 0xFFFF. Asserting rst_n low mid-stream clears all outputs to their reset values asynchronously.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: word width, feeder FSM states, underrun counter width.
// Used by the DSP stage, the sample feeder and the I2S transmitter.
package audio_pkg;

  localparam int AUDIO_W        = 32;
  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    UNDERRUN
  } feeder_state_e;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
    input logic [UNDERRUN_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/i2s_sample_feeder_if.sv
// Feeder bus: DSP push port (in_*), flush, transmitter request/data,
// and status (underrun, underrun_cnt, level, low_water).
interface i2s_sample_feeder_if
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_W,
  parameter int LVL_W  = 9
) ();

  logic [DATA_W-1:0]         in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      flush;
  logic                      tx_req;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      underrun;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt;
  logic [LVL_W-1:0]          level;
  logic                      low_water;

  modport master (
    output in_data, in_valid, flush, tx_req,
    input  in_ready, tx_data, tx_valid,
    input  underrun, underrun_cnt, level, low_water
  );

  modport slave (
    input  in_data, in_valid, flush, tx_req,
    output in_ready, tx_data, tx_valid,
    output underrun, underrun_cnt, level, low_water
  );

endinterface

// File: rtl/sample_ram.sv
// DEPTH x DATA_W simple dual-port RAM, registered read (block RAM).
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port.
module sample_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/i2s_sample_feeder.sv
// FIFO sample feeder for the I2S transmitter: primes, serves, plays silence.
// Ports: clk, rst_n (async, active-low), bus (i2s_sample_feeder_if.slave).
module i2s_sample_feeder
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUDIO_W,
  parameter int DEPTH     = 256,
  parameter int PRIME_LVL = 128,
  parameter int LOW_WM    = 16
) (
  input logic                clk,
  input logic                rst_n,
  i2s_sample_feeder_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PRIME_L   = LVL_W'(PRIME_LVL);
  localparam logic [LVL_W-1:0] LOW_L     = LVL_W'(LOW_WM);

  feeder_state_e state_q, state_d;

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             in_ready;
  logic             push, pop, ur_hit, ans;
  logic             primed, empty;

  logic              ans_q, pop_q, ur_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q, underrun_q, low_water_q;

  logic [UNDERRUN_CNT_W-1:0] ur_cnt_q, ur_cnt_d;

  assign in_ready = lvl_q < FULL_LVL;
  assign primed   = lvl_q >= PRIME_L;
  assign empty    = lvl_q == '0;
  assign push     = bus.in_valid & in_ready & ~bus.flush;
  assign ans      = bus.tx_req & ~bus.flush;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ur_hit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (primed) state_d = RUN;
      end
      RUN: begin
        if (bus.tx_req) begin
          if (empty) begin
            ur_hit  = 1'b1;
            state_d = UNDERRUN;
          end else begin
            pop = 1'b1;
          end
        end
      end
      UNDERRUN: begin
        if (primed) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      pop     = 1'b0;
      ur_hit  = 1'b0;
    end
  end

  always_comb begin
    lvl_d = lvl_q;
    unique case (1'b1)
      bus.flush:    lvl_d = '0;
      push & ~pop:  lvl_d = lvl_q + 1'b1;
      pop & ~push:  lvl_d = lvl_q - 1'b1;
      default:      lvl_d = lvl_q;
    endcase
  end

  assign ur_cnt_d = ur_hit ? sat_inc(ur_cnt_q) : ur_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Stage 1: RAM read + answer tag; stage 2: tx_data/tx_valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lvl_q       <= '0;
      low_water_q <= 1'b1;
      ur_cnt_q    <= '0;
      ans_q       <= 1'b0;
      pop_q       <= 1'b0;
      ur_q        <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      lvl_q       <= lvl_d;
      low_water_q <= lvl_d < LOW_L;
      ur_cnt_q    <= ur_cnt_d;
      if (bus.flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        ans_q      <= 1'b0;
        pop_q      <= 1'b0;
        ur_q       <= 1'b0;
        tx_data_q  <= '0;
        tx_valid_q <= 1'b0;
        underrun_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        ans_q      <= ans;
        pop_q      <= pop;
        ur_q       <= ur_hit;
        tx_valid_q <= ans_q;
        underrun_q <= ur_q;
        if (ans_q) tx_data_q <= pop_q ? ram_q : '0;
      end
    end
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.in_data),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (ram_q)
  );

  assign bus.in_ready     = in_ready;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = ur_cnt_q;
  assign bus.level        = lvl_q;
  assign bus.low_water    = low_water_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Self-checking bench for i2s_sample_feeder: vector table, FIFO/FSM model
// feeding a scoreboard of expected transmitter words.
module tb_i2s_sample_feeder;
  import audio_pkg::*;

  localparam int DEPTH = 256;
  localparam int PRIME = 128;
  localparam int LOWWM = 16;
  localparam int LVL_W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_sample_feeder_if #(.DATA_W(AUDIO_W), .LVL_W(LVL_W)) bus ();

  i2s_sample_feeder #(
    .DATA_W    (AUDIO_W),
    .DEPTH     (DEPTH),
    .PRIME_LVL (PRIME),
    .LOW_WM    (LOWWM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    bit          ur;
  } sb_t;

  sb_t           sb[$];
  logic [31:0]   mq[$];
  feeder_state_e ms;
  logic [15:0]   mcnt;
  logic [31:0]   last_tx;
  bit            pend;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          r;
    bit          f;
    int          lvl;
    bit          rdy;
    bit          lw;
  } vec_t;

  vec_t tbl[6];

  always @(negedge clk) begin
    sb_t e;
    if (bus.tx_valid) begin
      if (sb.size() == 0) begin
        chk("tx_valid_unexpected", 32'(bus.tx_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tx_data", bus.tx_data, e.d);
        chk("underrun_pulse", 32'(bus.underrun), 32'(e.ur));
        last_tx = e.d;
      end
    end else begin
      chk("underrun_quiet", 32'(bus.underrun), 32'd0);
      chk("tx_data_hold", bus.tx_data, last_tx);
    end
  end

  task automatic cyc(input bit v, input logic [31:0] d,
                     input bit r, input bit f);
    int            lvl;
    feeder_state_e os;
    sb_t           e;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.tx_req   = r;
    bus.flush    = f;
    @(posedge clk);
    lvl = mq.size();
    os  = ms;
    if (f) begin
      if (pend) void'(sb.pop_back());
      pend = 1'b0;
      mq.delete();
      ms = IDLE;
      last_tx = '0;
    end else begin
      pend = r;
      if (r) begin
        e.ur = 1'b0;
        e.d  = '0;
        if (os == RUN && lvl > 0) begin
          e.d = mq.pop_front();
        end else if (os == RUN) begin
          e.ur = 1'b1;
          ms   = UNDERRUN;
          if (mcnt != 16'hFFFF) mcnt++;
        end
        sb.push_back(e);
      end
      if (v && lvl < DEPTH) mq.push_back(d);
      if (os != RUN && lvl >= PRIME) ms = RUN;
    end
    #1;
    chk("level", 32'(bus.level), 32'(mq.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    chk("low_water", 32'(bus.low_water), 32'(mq.size() < LOWWM));
    chk("underrun_cnt", 32'(bus.underrun_cnt), 32'(mcnt));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_underrun();
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < PRIME; i++) cyc(1'b1, 32'h500 + i, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < PRIME; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.tx_req   = 1'b0;
    bus.flush    = 1'b0;
    ms      = IDLE;
    mcnt    = '0;
    pend    = 1'b0;
    last_tx = '0;

    tbl[0] = '{0, 32'h0,  0, 0, 0, 1, 1};
    tbl[1] = '{1, 32'hAA, 0, 0, 1, 1, 1};
    tbl[2] = '{1, 32'hBB, 1, 0, 2, 1, 1};
    tbl[3] = '{1, 32'hCC, 1, 1, 0, 1, 1};
    tbl[4] = '{1, 32'hDD, 0, 0, 1, 1, 1};
    tbl[5] = '{0, 32'h0,  0, 1, 0, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_data", bus.tx_data, 32'h0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_underrun", 32'(bus.underrun), 32'd0);
    chk("rst_cnt", 32'(bus.underrun_cnt), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_low_water", 32'(bus.low_water), 32'd1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      chk("tbl_level", 32'(bus.level), 32'(tbl[i].lvl));
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[i].rdy));
      chk("tbl_low_water", 32'(bus.low_water), 32'(tbl[i].lw));
    end
    idle(2);

    for (int i = 1; i <= 127; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("prime_no_pop", 32'(bus.level), 32'd127);
    cyc(1'b1, 32'h80, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("prime_pop", 32'(bus.level), 32'd127);
    idle(2);
    chk("prime_first_word", bus.tx_data, 32'h1);

    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 128; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 128; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    chk("stream_last", bus.tx_data, 32'h17F);
    chk("stream_no_ur", 32'(bus.underrun_cnt), 32'd0);

    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    chk("ur_cnt_first", 32'(bus.underrun_cnt), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    chk("ur_cnt_held", 32'(bus.underrun_cnt), 32'd1);
    for (int i = 0; i < 128; i++) cyc(1'b1, 32'h200 + i, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    chk("recover_word", bus.tx_data, 32'h200);

    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) cyc(1'b1, 32'h300 + i, 1'b0, 1'b0);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_level", 32'(bus.level), 32'd256);
    cyc(1'b1, 32'hDEAD, 1'b1, 1'b0);
    chk("full_pop_level", 32'(bus.level), 32'd255);
    chk("full_pop_ready", 32'(bus.in_ready), 32'd1);
    idle(2);
    chk("full_pop_word", bus.tx_data, 32'h300);

    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) cyc(1'b1, 32'h600 + i, 1'b0, 1'b0);
    idle(1);
    cyc(1'b1, 32'hBEEF, 1'b1, 1'b1);
    chk("flush_level", 32'(bus.level), 32'd0);
    idle(2);
    chk("flush_tx_data", bus.tx_data, 32'h0);
    chk("flush_cnt", 32'(bus.underrun_cnt), 32'd1);
    cyc(1'b1, 32'h42, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("flush_idle_no_pop", 32'(bus.level), 32'd1);
    idle(2);

    force dut.ur_cnt_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.ur_cnt_q;
    mcnt = 16'hFFFD;
    do_underrun();
    chk("sat_fffe", 32'(bus.underrun_cnt), 32'hFFFE);
    do_underrun();
    chk("sat_ffff", 32'(bus.underrun_cnt), 32'hFFFF);
    do_underrun();
    chk("sat_hold", 32'(bus.underrun_cnt), 32'hFFFF);

    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 128; i++) cyc(1'b1, 32'h700 + i, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h800 + i, 1'b1, 1'b0);
    rst_n = 1'b0;
    bus.tx_req   = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    sb.delete();
    mq.delete();
    pend    = 1'b0;
    ms      = IDLE;
    mcnt    = '0;
    last_tx = '0;
    chk("arst_tx_data", bus.tx_data, 32'h0);
    chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("arst_underrun", 32'(bus.underrun), 32'd0);
    chk("arst_cnt", 32'(bus.underrun_cnt), 32'd0);
    chk("arst_level", 32'(bus.level), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_low_water", 32'(bus.low_water), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
